multi_queue_fifo: RTL and testbench
===================================

MULTI_QUEUE_FIFO -- requirements
Module: multi_queue_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of stored word.
REQ-002 Parameter NUM_QUEUES, default 4, number of independent queues (1..64).
REQ-003 Parameter DEPTH, default 16, entries per queue, power of two, >=2.
REQ-004 Parameter AFULL_LEVEL, default DEPTH-2, almost-full threshold (1..DEPTH).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 wr_valid  in  1  write request.
REQ-008 wr_qid  in  QW=max(1,clog2(NUM_QUEUES))  target queue of write.
REQ-009 wr_data  in  DATA_WIDTH  write word.
REQ-010 wr_ready  out  1  combinational; =1 iff wr_qid is in range and the queue is not full.
REQ-011 rd_req  in  1  read request.
REQ-012 rd_qid  in  QW  source queue of read.
REQ-013 rd_valid  out  1  registered; rd_data valid this cycle.
REQ-014 rd_data  out  DATA_WIDTH  registered read word.
REQ-015 rd_err  out  1  registered one-cycle pulse; read request rejected.
REQ-016 q_empty, q_full, q_afull  out  NUM_QUEUES each  per-queue status, bit i = queue i.
REQ-017 q_count  out  NUM_QUEUES*CW, CW=clog2(DEPTH+1)  per-queue occupancy, queue i at bits [i*CW +: CW].
REQ-018 drop_cnt  out  32  saturating count of rejected writes.

Function
REQ-019 Write accepted iff wr_valid && wr_ready; word stored at tail of queue wr_qid, tail pointer advances by 1 modulo DEPTH.
REQ-020 wr_valid && !wr_ready: word discarded, drop_cnt +1, saturating at 0xFFFFFFFF.
REQ-021 Read accepted iff rd_req, rd_qid in range and queue not empty; head word appears on rd_data with rd_valid=1 exactly one cycle later; head pointer advances modulo DEPTH.
REQ-022 Read rejected (empty or out-of-range qid): no state change, rd_err=1 next cycle, rd_valid=0.
REQ-023 rd_data holds last value when rd_valid=0.
REQ-024 Full/empty evaluated on pre-edge count: write to a full queue is dropped even with a same-cycle read of that queue; read of an empty queue is rejected even with a same-cycle write (no bypass).
REQ-025 Same-queue accepted write+read in one cycle: count unchanged, both pointers advance.
REQ-026 Different-queue write and read in one cycle proceed independently.
REQ-027 q_empty[i]=(count==0), q_full[i]=(count==DEPTH), q_afull[i]=(count>=AFULL_LEVEL), all derived combinationally from registered counts.
REQ-028 Pointers are clog2(DEPTH) bits and wrap naturally; count is the sole full/empty source.

Reset
REQ-029 On rst: all pointers, counts, drop_cnt = 0; rd_valid=0, rd_err=0, rd_data=0; q_empty=all ones, q_full=q_afull=0.
REQ-030 Storage array is not reset; contents are undefined until written.
REQ-031 rst asserted mid-operation discards all queued data; requests in the rst cycle are ignored, and drop_cnt does not count them.

Structure
REQ-032 Shared package holds QW, CW and pointer-width derivation functions and the drop-counter width constant.
REQ-033 Storage is one flat array of NUM_QUEUES*DEPTH words addressed {qid, ptr}, with one write port and one registered read port.
REQ-034 Per-queue head/tail/count logic lives in sub-module mq_fifo_ctrl, instantiated NUM_QUEUES times via generate.

Verification (DATA_WIDTH=8, NUM_QUEUES=4, DEPTH=4, AFULL_LEVEL=3 unless noted)
REQ-035 Write 0x11,0x22,0x33 to q1, then read q1 three times -> rd_data 0x11,0x22,0x33 each one cycle after request; q_empty[1]=1 at end.
REQ-036 Write 5 words to q2 -> 4 accepted, q_full[2]=1, q_afull[2]=1 after 3rd word, drop_cnt=1; others' status unchanged.
REQ-037 q2 full, simultaneous write q2 and read q2 -> read returns oldest word, write dropped, drop_cnt+1, count 3.
REQ-038 q0 empty, simultaneous write 0xAA to q0 and read q0 -> rd_err pulse, q_count[0]=1; next read returns 0xAA.
REQ-039 Ten write/read pairs on q3 -> data in order across pointer wrap; NUM_QUEUES=3 run: wr_qid=3 drops, rd_qid=3 gives rd_err.
REQ-040 Fill q0 with 2 words, assert rst one cycle -> all counts 0, q_empty=4'b1111, drop_cnt=0, subsequent read of q0 gives rd_err.

Source files
------------

// File: rtl/multi_queue_fifo_pkg.sv
// Shared width derivations for the multi-queue FIFO and its per-queue controller.
package multi_queue_fifo_pkg;

  // Width of the saturating rejected-write counter.
  localparam int DROP_CNT_W = 32;

  // Queue-id width; a single queue still needs a one-bit id port.
  function automatic int qid_width(input int num_queues);
    return (num_queues > 1) ? $clog2(num_queues) : 1;
  endfunction

  // Occupancy width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Head/tail pointer width; pointers wrap naturally at depth (a power of two).
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mq_fifo_ctrl.sv
// Head/tail/occupancy bookkeeping for one queue of the multi-queue FIFO.
// The occupancy count is the only source of full/empty; pointers just wrap.
module mq_fifo_ctrl
  import multi_queue_fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2,
  localparam int PW = ptr_width(DEPTH),
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,   // accepted write to this queue
  input  logic          rd_en_i,   // accepted read from this queue
  output logic [PW-1:0] head_o,
  output logic [PW-1:0] tail_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          afull_o
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state: advance pointers on accepted ops; count moves only when exactly one op happens.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wr_en_i) tail_d = tail_q + 1'b1;
    if (rd_en_i) head_d = head_q + 1'b1;
    case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign afull_o = (count_q >= CW'(AFULL_LEVEL));

endmodule

// File: rtl/multi_queue_fifo.sv
// NUM_QUEUES independent FIFOs sharing one flat storage array addressed {qid, ptr}.
// Full/empty decisions use pre-edge occupancy, so there is no write-to-read bypass.
module multi_queue_fifo
  import multi_queue_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_QUEUES  = 4,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2,
  localparam int QW = qid_width(NUM_QUEUES),
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [QW-1:0]            wr_qid,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_ready,
  input  logic                     rd_req,
  input  logic [QW-1:0]            rd_qid,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_err,
  output logic [NUM_QUEUES-1:0]    q_empty,
  output logic [NUM_QUEUES-1:0]    q_full,
  output logic [NUM_QUEUES-1:0]    q_afull,
  output logic [NUM_QUEUES*CW-1:0] q_count,
  output logic [DROP_CNT_W-1:0]    drop_cnt
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = QW + PW;

  logic [NUM_QUEUES-1:0] wr_en, rd_en;
  logic [PW-1:0]         head [NUM_QUEUES];
  logic [PW-1:0]         tail [NUM_QUEUES];
  logic                  wr_sel_full, rd_sel_empty;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;

  logic [DATA_WIDTH-1:0] mem [NUM_QUEUES*DEPTH];
  logic                  rd_valid_q, rd_err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Select status and pointer of the addressed queues; an out-of-range id matches
  // nothing and so reads as full (for writes) and empty (for reads).
  always_comb begin
    wr_sel_full  = 1'b1;
    rd_sel_empty = 1'b1;
    wr_ptr       = '0;
    rd_ptr       = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (wr_qid == QW'(i)) begin
        wr_sel_full = q_full[i];
        wr_ptr      = tail[i];
      end
      if (rd_qid == QW'(i)) begin
        rd_sel_empty = q_empty[i];
        rd_ptr       = head[i];
      end
    end
  end

  assign wr_ready = !wr_sel_full;
  assign wr_acc   = wr_valid && wr_ready && !rst;
  assign rd_acc   = rd_req && !rd_sel_empty && !rst;

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
    assign wr_en[g] = wr_acc && (wr_qid == QW'(g));
    assign rd_en[g] = rd_acc && (rd_qid == QW'(g));

    mq_fifo_ctrl #(
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (AFULL_LEVEL)
    ) u_ctrl (
      .clk     (clk),
      .rst     (rst),
      .wr_en_i (wr_en[g]),
      .rd_en_i (rd_en[g]),
      .head_o  (head[g]),
      .tail_o  (tail[g]),
      .count_o (q_count[g*CW +: CW]),
      .empty_o (q_empty[g]),
      .full_o  (q_full[g]),
      .afull_o (q_afull[g])
    );
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy counts alone say what is valid.
    if (wr_acc) mem[AW'({wr_qid, wr_ptr})] <= wr_data;
  end

  // Registered read port with valid/error strobes; rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      rd_err_q   <= rd_req && !rd_acc;
      if (rd_acc) rd_data_q <= mem[AW'({rd_qid, rd_ptr})];
    end
  end

  // Saturating count of rejected writes.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (wr_valid && !wr_ready && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Drop counter register; requests in a reset cycle are not counted.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_multi_queue_fifo.sv
// Self-checking bench for multi_queue_fifo: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_multi_queue_fifo;

  localparam int NQ    = 4;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [1:0]  wr_qid;
  logic [7:0]  wr_data;
  logic        rd_req;
  logic [1:0]  rd_qid;

  logic        wr_ready, rd_valid, rd_err;
  logic [7:0]  rd_data;
  logic [3:0]  q_empty, q_full, q_afull;
  logic [11:0] q_count;
  logic [31:0] drop_cnt;

  logic        wr_ready3, rd_valid3, rd_err3;
  logic [7:0]  rd_data3;
  logic [2:0]  q_empty3, q_full3, q_afull3;
  logic [8:0]  q_count3;
  logic [31:0] drop_cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_queue_fifo #(.DATA_WIDTH(8), .NUM_QUEUES(NQ), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_qid(wr_qid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_qid(rd_qid), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .q_empty(q_empty), .q_full(q_full), .q_afull(q_afull), .q_count(q_count), .drop_cnt(drop_cnt)
  );

  // Three-queue instance shares the stimulus; used only for out-of-range id checks.
  multi_queue_fifo #(.DATA_WIDTH(8), .NUM_QUEUES(3), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut3 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_qid(wr_qid), .wr_data(wr_data), .wr_ready(wr_ready3),
    .rd_req(rd_req), .rd_qid(rd_qid), .rd_valid(rd_valid3), .rd_data(rd_data3), .rd_err(rd_err3),
    .q_empty(q_empty3), .q_full(q_full3), .q_afull(q_afull3), .q_count(q_count3), .drop_cnt(drop_cnt3)
  );

  // Reference model: one queue per FIFO plus the output registers.
  logic [7:0]  mq [NQ][$];
  logic [31:0] m_drop;
  logic        m_rd_valid, m_rd_err;
  logic [7:0]  m_rd_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus (called at negedge), advance the model, compare everything.
  task automatic step(input logic r, input logic wv, input logic [1:0] wq, input logic [7:0] wd,
                      input logic rr, input logic [1:0] rq);
    logic        wok, rok;
    logic [11:0] e_cnt;
    logic [3:0]  e_emp, e_ful, e_af;
    rst = r; wr_valid = wv; wr_qid = wq; wr_data = wd; rd_req = rr; rd_qid = rq;
    #1;
    wok = (mq[wq].size() < DEPTH);
    rok = (mq[rq].size() > 0);
    if (!r) check("wr_ready", {63'd0, wr_ready}, {63'd0, wok});
    @(posedge clk);
    if (r) begin
      for (int q = 0; q < NQ; q++) mq[q].delete();
      m_drop = 0; m_rd_valid = 0; m_rd_err = 0; m_rd_data = 8'h00;
    end else begin
      m_rd_valid = rr && rok;
      m_rd_err   = rr && !rok;
      if (rr && rok) m_rd_data = mq[rq].pop_front();
      if (wv && wok) mq[wq].push_back(wd);
      if (wv && !wok && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
    end
    #1;
    for (int q = 0; q < NQ; q++) begin
      e_cnt[q*3 +: 3] = 3'(mq[q].size());
      e_emp[q] = (mq[q].size() == 0);
      e_ful[q] = (mq[q].size() == DEPTH);
      e_af[q]  = (mq[q].size() >= AFULL);
    end
    check("rd_valid", {63'd0, rd_valid}, {63'd0, m_rd_valid});
    check("rd_err",   {63'd0, rd_err},   {63'd0, m_rd_err});
    check("rd_data",  {56'd0, rd_data},  {56'd0, m_rd_data});
    check("drop_cnt", {32'd0, drop_cnt}, {32'd0, m_drop});
    check("q_count",  {52'd0, q_count},  {52'd0, e_cnt});
    check("q_flags",  {52'd0, q_empty, q_full, q_afull}, {52'd0, e_emp, e_ful, e_af});
    @(negedge clk);
  endtask

  typedef struct {
    logic        wv;
    logic [1:0]  wq;
    logic [7:0]  wd;
    logic        rr;
    logic [1:0]  rq;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_err;
    logic [31:0] e_drop;
    logic [3:0]  e_empty;
    logic [3:0]  e_full;
    logic [3:0]  e_afull;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic [1:0] wq, input logic [7:0] wd,
                              input logic rr, input logic [1:0] rq, input logic ev,
                              input logic [7:0] ed, input logic ee, input logic [31:0] edrop,
                              input logic [3:0] eemp, input logic [3:0] eful, input logic [3:0] eaf);
    vec_t v;
    v.wv = wv; v.wq = wq; v.wd = wd; v.rr = rr; v.rq = rq;
    v.e_valid = ev; v.e_data = ed; v.e_err = ee; v.e_drop = edrop;
    v.e_empty = eemp; v.e_full = eful; v.e_afull = eaf;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // q1 in-order read-back, q2 overflow, full/empty same-cycle corners.
    vecs[0]  = mk(1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 32'd0, 4'b1101, 4'b0000, 4'b0000);
    vecs[1]  = mk(1'b1, 2'd1, 8'h22, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 32'd0, 4'b1101, 4'b0000, 4'b0000);
    vecs[2]  = mk(1'b1, 2'd1, 8'h33, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 32'd0, 4'b1101, 4'b0000, 4'b0010);
    vecs[3]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h11, 1'b0, 32'd0, 4'b1101, 4'b0000, 4'b0000);
    vecs[4]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h22, 1'b0, 32'd0, 4'b1101, 4'b0000, 4'b0000);
    vecs[5]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h33, 1'b0, 32'd0, 4'b1111, 4'b0000, 4'b0000);
    vecs[6]  = mk(1'b1, 2'd2, 8'hA1, 1'b0, 2'd0, 1'b0, 8'h33, 1'b0, 32'd0, 4'b1011, 4'b0000, 4'b0000);
    vecs[7]  = mk(1'b1, 2'd2, 8'hA2, 1'b0, 2'd0, 1'b0, 8'h33, 1'b0, 32'd0, 4'b1011, 4'b0000, 4'b0000);
    vecs[8]  = mk(1'b1, 2'd2, 8'hA3, 1'b0, 2'd0, 1'b0, 8'h33, 1'b0, 32'd0, 4'b1011, 4'b0000, 4'b0100);
    vecs[9]  = mk(1'b1, 2'd2, 8'hA4, 1'b0, 2'd0, 1'b0, 8'h33, 1'b0, 32'd0, 4'b1011, 4'b0100, 4'b0100);
    vecs[10] = mk(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 1'b0, 8'h33, 1'b0, 32'd1, 4'b1011, 4'b0100, 4'b0100);
    vecs[11] = mk(1'b1, 2'd2, 8'hB0, 1'b1, 2'd2, 1'b1, 8'hA1, 1'b0, 32'd2, 4'b1011, 4'b0000, 4'b0100);
    vecs[12] = mk(1'b1, 2'd0, 8'hAA, 1'b1, 2'd0, 1'b0, 8'hA1, 1'b1, 32'd2, 4'b1010, 4'b0000, 4'b0100);
    vecs[13] = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 8'hAA, 1'b0, 32'd2, 4'b1011, 4'b0000, 4'b0100);

    rst = 1'b1; wr_valid = 1'b0; wr_qid = '0; wr_data = '0; rd_req = 1'b0; rd_qid = '0;
    for (int q = 0; q < NQ; q++) mq[q].delete();
    m_drop = 0; m_rd_valid = 0; m_rd_err = 0; m_rd_data = 8'h00;
    @(negedge clk);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    check("reset_empty", {60'd0, q_empty}, {60'd0, 4'b1111});
    check("reset_count", {52'd0, q_count}, 64'd0);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      step(1'b0, vecs[i].wv, vecs[i].wq, vecs[i].wd, vecs[i].rr, vecs[i].rq);
      check($sformatf("vec%0d_valid", i), {63'd0, rd_valid}, {63'd0, vecs[i].e_valid});
      check($sformatf("vec%0d_data", i),  {56'd0, rd_data},  {56'd0, vecs[i].e_data});
      check($sformatf("vec%0d_err", i),   {63'd0, rd_err},   {63'd0, vecs[i].e_err});
      check($sformatf("vec%0d_drop", i),  {32'd0, drop_cnt}, {32'd0, vecs[i].e_drop});
      check($sformatf("vec%0d_empty", i), {60'd0, q_empty},  {60'd0, vecs[i].e_empty});
      check($sformatf("vec%0d_full", i),  {60'd0, q_full},   {60'd0, vecs[i].e_full});
      check($sformatf("vec%0d_afull", i), {60'd0, q_afull},  {60'd0, vecs[i].e_afull});
    end
    check("q2_count_after_full_rw", {61'd0, q_count[8:6]}, 64'd3);

    // Ten write/read pairs on q3 across pointer wrap.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 2'd3, 8'(8'h30 + k), 1'b0, 2'd0);
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
      check("q3_wrap_valid", {63'd0, rd_valid}, 64'd1);
      check("q3_wrap_data", {56'd0, rd_data}, 64'(8'h30 + k));
    end

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom),
           1'($urandom), 2'($urandom_range(0, 3)));
    end

    // Reset mid-operation with requests present in the reset cycle.
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 2'd1, 8'(8'h60 + k), 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd0, 8'h71, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd0, 8'h72, 1'b0, 2'd0);
    check("pre_rst_drop", {32'd0, drop_cnt}, 64'd1);
    step(1'b1, 1'b1, 2'd1, 8'h73, 1'b1, 2'd0);
    check("rst_count", {52'd0, q_count}, 64'd0);
    check("rst_empty", {60'd0, q_empty}, {60'd0, 4'b1111});
    check("rst_drop", {32'd0, drop_cnt}, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    check("rd_after_rst_err", {63'd0, rd_err}, 64'd1);

    // Three-queue instance: id 3 is out of range for both write and read.
    step(1'b0, 1'b1, 2'd3, 8'h77, 1'b0, 2'd0);
    check("nq3_wr_ready_oor", {63'd0, wr_ready3}, 64'd0);
    check("nq3_drop_oor", {32'd0, drop_cnt3}, 64'd1);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    check("nq3_rd_err_oor", {63'd0, rd_err3}, 64'd1);
    check("nq3_rd_valid_oor", {63'd0, rd_valid3}, 64'd0);
    step(1'b0, 1'b1, 2'd2, 8'h99, 1'b0, 2'd0);
    check("nq3_q2_count", {55'd0, q_count3}, {55'd0, 9'b001_000_000});
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
    check("nq3_rd_data", {56'd0, rd_data3}, 64'h99);
    check("nq3_drop_final", {32'd0, drop_cnt3}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
